// File: rtl/rtc_init_sequencer_if.sv
// Write-controller side of the RTC init sequencer: cycle handshake plus the
// multiplexed AD bus. The sequencer is master; the write controller and pads are slave.
interface rtc_init_sequencer_if;
   logic       ciclo;
   logic       Fin;
   logic       Sent_A;
   logic       Sent_D;
   logic [7:0] bus_out;
   logic       bus_oe;

   modport master (output ciclo, bus_out, bus_oe, input Fin, Sent_A, Sent_D);
   modport slave  (input ciclo, bus_out, bus_oe, output Fin, Sent_A, Sent_D);
endinterface

// File: rtl/rtc_init_sequencer.sv
// Walks a fixed RTC register-programming table, one write cycle per entry.
// Define RTC_INIT_COMMIT_EN to append the transfer/commit entry (0xF0, 0xF0).
module rtc_init_sequencer #(
   parameter int unsigned WAIT_TIMEOUT = 16384
) (
   input  logic                       Clock_in,
   input  logic                       Reset,
   input  logic                       start,
   rtc_init_sequencer_if.master       wr,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [2:0]                 idx
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
   } state_t;

`ifdef RTC_INIT_COMMIT_EN
   localparam logic [2:0] LAST = 3'd4;
`else
   localparam logic [2:0] LAST = 3'd3;
`endif

   localparam int unsigned CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

   // {addr, data} for each entry
   function automatic logic [15:0] table_entry(input logic [2:0] i);
      case (i)
         3'd0:    return {8'h02, 8'h10};
         3'd1:    return {8'h10, 8'h00};
         3'd2:    return {8'h11, 8'h00};
         3'd3:    return {8'h12, 8'h00};
`ifdef RTC_INIT_COMMIT_EN
         3'd4:    return {8'hF0, 8'hF0};
`endif
         default: return 16'h0000;
      endcase
   endfunction

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       addr_r, data_r;
   logic             go, load_en, idx_inc, cnt_clr, cnt_inc;

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n = state;
      go      = 1'b0;
      load_en = 1'b0;
      idx_inc = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               go      = 1'b1;
               state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            load_en = 1'b1;
            state_n = S_ISSUE;
         end
         S_ISSUE: begin
            cnt_clr = 1'b1;
            state_n = S_WAIT;
         end
         S_WAIT: begin
            if (wr.Fin) begin
               if (idx == LAST) begin
                  state_n = S_DONE;
               end else begin
                  idx_inc = 1'b1;
                  state_n = S_GAP;
               end
            end else if (cnt == CNT_LAST) begin
               state_n = S_ERROR;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_GAP:   state_n = S_LOAD;
         default: state_n = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clock_in) begin
      if (Reset) begin
         state  <= S_IDLE;
         idx    <= 3'd0;
         cnt    <= '0;
         addr_r <= 8'h00;
         data_r <= 8'h00;
      end else begin
         state <= state_n;
         if (go)           idx <= 3'd0;
         else if (idx_inc) idx <= idx + 3'd1;
         if (go || cnt_clr) cnt <= '0;
         else if (cnt_inc)  cnt <= cnt + 1'b1;
         if (load_en) {addr_r, data_r} <= table_entry(idx);
      end
   end

   assign wr.ciclo = (state == S_ISSUE);
   assign busy     = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERROR);

   // Address strobe has priority when both strobes are high
   always_comb begin
      wr.bus_out = 8'h00;
      if (wr.Sent_A)      wr.bus_out = addr_r;
      else if (wr.Sent_D) wr.bus_out = data_r;
   end
   assign wr.bus_oe = wr.Sent_A | wr.Sent_D;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Scoreboard bench for rtc_init_sequencer: a write-controller model answers each
// ciclo, and a monitor pops queued expectations for ciclo pulses and bus samples.
module tb_rtc_init_sequencer;

`ifdef RTC_INIT_COMMIT_EN
   localparam int LAST_TB = 4;
`else
   localparam int LAST_TB = 3;
`endif
   localparam int FIN_DELAY = 130;
   localparam int PERIOD_TB = FIN_DELAY + 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic busy, done, err;
   logic [2:0] idx;

   logic mdl_a = 1'b0, mdl_d = 1'b0, mdl_fin = 1'b0, mdl_chk = 1'b0;
   logic man_a = 1'b0, man_d = 1'b0, man_fin = 1'b0, man_chk = 1'b0;
   int   drop_idx = 7;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [7:0] tb_addr [0:4] = '{8'h02, 8'h10, 8'h11, 8'h12, 8'hF0};
   logic [7:0] tb_data [0:4] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hF0};

   typedef struct packed { logic [31:0] idx; logic [31:0] cyc; } ciclo_exp_t;
   typedef struct packed { logic [7:0] bus; logic oe; } bus_exp_t;
   ciclo_exp_t ciclo_q[$];
   bus_exp_t   bus_q[$];

   rtc_init_sequencer_if wr();

   assign wr.Sent_A = mdl_a | man_a;
   assign wr.Sent_D = mdl_d | man_d;
   assign wr.Fin    = mdl_fin | man_fin;

   rtc_init_sequencer dut (
      .Clock_in (clk),
      .Reset    (rst),
      .start    (start),
      .wr       (wr),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .idx      (idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      do @(negedge clk); while (cyc < target);
   endtask

   // Pulses start and queues the ciclo pulses that run should produce
   task automatic do_start(input int n_entries, output int s);
      tick();
      start = 1'b1;
      s = cyc;
      for (int k = 0; k < n_entries; k++)
         ciclo_q.push_back('{idx: 32'(k), cyc: 32'(s + 2 + PERIOD_TB * k)});
      tick();
      start = 1'b0;
   endtask

   // Write-controller model: strobes the bus during each cycle, then returns Fin
   initial begin
      int t = 0;
      int ent = 0;
      int ent_cnt = 0;
      bit act = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            act = 1'b0;
            ent_cnt = 0;
         end else if (start && !act) begin
            ent_cnt = 0;
         end else if (wr.ciclo) begin
            act = 1'b1;
            t = 0;
            ent = ent_cnt;
            ent_cnt++;
         end
         @(posedge clk);
         #1;
         mdl_a = 1'b0; mdl_d = 1'b0; mdl_fin = 1'b0; mdl_chk = 1'b0;
         if (act) begin
            t++;
            case (t)
               10: begin mdl_a = 1'b1; mdl_chk = 1'b1; bus_q.push_back('{bus: tb_addr[ent], oe: 1'b1}); end
               20: begin mdl_d = 1'b1; mdl_chk = 1'b1; bus_q.push_back('{bus: tb_data[ent], oe: 1'b1}); end
               30: begin mdl_chk = 1'b1; bus_q.push_back('{bus: 8'h00, oe: 1'b0}); end
               40: if (ent == 0) begin
                      mdl_a = 1'b1; mdl_d = 1'b1; mdl_chk = 1'b1;
                      bus_q.push_back('{bus: 8'h02, oe: 1'b1});
                   end
               FIN_DELAY: begin
                  if (ent != drop_idx) mdl_fin = 1'b1;
                  act = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a ciclo or a bus sample is due
   initial begin
      ciclo_exp_t ce;
      bus_exp_t   be;
      forever begin
         @(negedge clk);
         if (wr.ciclo === 1'b1) begin
            if (ciclo_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ciclo actual=1 expected=0 (cycle %0d, idx %0d)", cyc, idx);
            end else begin
               ce = ciclo_q.pop_front();
               check("ciclo_idx", 32'(idx), ce.idx);
               check("ciclo_cycle", 32'(cyc), ce.cyc);
            end
         end
         if (mdl_chk | man_chk) begin
            if (bus_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL bus_sample_unqueued actual=%0h expected=none (cycle %0d)", wr.bus_out, cyc);
            end else begin
               be = bus_q.pop_front();
               check("bus_out", 32'(wr.bus_out), 32'(be.bus));
               check("bus_oe", 32'(wr.bus_oe), 32'(be.oe));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s;
      int t_done;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_idx", 32'(idx), 0);
      check("rst_ciclo", 32'(wr.ciclo), 0);
      tick();
      man_chk = 1'b1;
      bus_q.push_back('{bus: 8'h00, oe: 1'b0});
      tick();
      man_chk = 1'b0;

      // Spurious Fin in IDLE: no ciclo, no state change
      man_fin = 1'b1;
      tick();
      man_fin = 1'b0;
      @(negedge clk);
      check("idle_fin_busy", 32'(busy), 0);
      check("idle_fin_idx", 32'(idx), 0);
      check("idle_fin_done", 32'(done), 0);

      // Full run, with a start re-pulse during WAIT of entry 1
      drop_idx = 7;
      do_start(LAST_TB + 1, s);
      wait_cyc(s + 2 + PERIOD_TB + 50);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      t_done = s + 2 + PERIOD_TB * LAST_TB + FIN_DELAY + 1;
      wait_cyc(t_done - 1);
      check("run1_pre_done", 32'(done), 0);
      check("run1_pre_busy", 32'(busy), 1);
      wait_cyc(t_done);
      check("run1_done", 32'(done), 1);
      check("run1_busy", 32'(busy), 0);
      check("run1_idx", 32'(idx), 32'(LAST_TB));
      check("run1_err", 32'(err), 0);

      // No Fin after the second ciclo: timeout
      drop_idx = 1;
      do_start(2, s);
      @(negedge clk);
      check("run2_load_done_cleared", 32'(done), 0);
      wait_cyc(s + 2 + PERIOD_TB + 16384);
      check("tmo_pre_err", 32'(err), 0);
      check("tmo_pre_busy", 32'(busy), 1);
      wait_cyc(s + 2 + PERIOD_TB + 16385);
      check("tmo_err", 32'(err), 1);
      check("tmo_idx", 32'(idx), 1);
      check("tmo_busy", 32'(busy), 0);
      check("tmo_done", 32'(done), 0);

      // Restart from ERROR
      drop_idx = 7;
      do_start(LAST_TB + 1, s);
      @(negedge clk);
      check("rerun_err_cleared", 32'(err), 0);
      check("rerun_idx", 32'(idx), 0);
      check("rerun_busy", 32'(busy), 1);
      wait_cyc(s + 2 + PERIOD_TB * LAST_TB + FIN_DELAY + 1);
      check("rerun_done", 32'(done), 1);
      check("rerun_idx_end", 32'(idx), 32'(LAST_TB));

      // Reset during WAIT of entry 2
      do_start(3, s);
      wait_cyc(s + 2 + 2 * PERIOD_TB + 50);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_idx", 32'(idx), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_ciclo", 32'(wr.ciclo), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_err", 32'(err), 0);
      tick();
      man_a = 1'b1; man_chk = 1'b1;
      bus_q.push_back('{bus: 8'h00, oe: 1'b1});
      tick();
      man_a = 1'b0; man_d = 1'b1;
      bus_q.push_back('{bus: 8'h00, oe: 1'b1});
      tick();
      man_d = 1'b0;
      bus_q.push_back('{bus: 8'h00, oe: 1'b0});
      tick();
      man_chk = 1'b0;

      repeat (FIN_DELAY + 20) tick();
      check("ciclo_q_drained", 32'(ciclo_q.size()), 0);
      check("bus_q_drained", 32'(bus_q.size()), 0);
      check("final_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rtc_init_sequencer.md
# rtc_init_sequencer

Upstream feeder for the RTC write-cycle controller: on one `start` pulse it walks a fixed table of address/data pairs. For each pair it pulses `ciclo`, then waits for `Fin`. It drives the multiplexed 8-bit AD bus with the address while `Sent_A` is high and with the data while `Sent_D` is high. The block sits between the top-level control logic and the write-cycle controller/bus pads, and bring-up of the RTC uses it to program the chip's registers.

## Interface
- `WAIT_TIMEOUT`, 16384, clock cycles allowed between `ciclo` and `Fin` before error.
- `Clock_in`  in  1  system clock, 100 MHz.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to run the table; ignored unless in IDLE or DONE/ERROR.
- `Fin`  in  1  end-of-cycle pulse from write controller.
- `Sent_A`  in  1  write controller address-phase strobe.
- `Sent_D`  in  1  write controller data-phase strobe.
- `ciclo`  out  1  one-cycle start pulse to write controller.
- `bus_out`  out  8  value for AD pads.
- `bus_oe`  out  1  pad output enable.
- `busy`  out  1  high from accepted `start` until DONE/ERROR.
- `done`  out  1  level, high in DONE.
- `err`  out  1  level, high in ERROR.
- `idx`  out  3  index of current table entry.

## Operation
- Table (addr, data): 0:(0x02,0x10), 1:(0x10,0x00), 2:(0x11,0x00), 3:(0x12,0x00). The last index is LAST = 3, or 4 with the commit entry enabled.
- States: IDLE, LOAD, ISSUE, WAIT, GAP, DONE, ERROR.
- IDLE/DONE/ERROR + `start` → LOAD. The transition clears `idx`, `done`, `err` and the timeout counter.
- LOAD: latch `addr_r`/`data_r` from table[`idx`] → ISSUE.
- ISSUE: `ciclo`=1 for exactly this cycle; clear timeout counter → WAIT.
- WAIT: counter increments each cycle.
  - `Fin`=1 and `idx`==LAST → DONE.
  - `Fin`=1 otherwise → `idx`+1, GAP.
  - Counter reaches WAIT_TIMEOUT−1 without `Fin` → ERROR; `idx` holds the failing entry.
- GAP: one idle cycle so the write controller settles in its idle state → LOAD.
- `Fin` outside WAIT is ignored. `start` in LOAD/ISSUE/WAIT/GAP is ignored.
- Bus mux (combinational from latched registers and strobes):
  - `Sent_A`=1 → `bus_out`=`addr_r`.
  - else `Sent_D`=1 → `bus_out`=`data_r`.
  - else `bus_out`=0x00.
  - `bus_oe` = `Sent_A` | `Sent_D`. `Sent_A` wins if both are high.
- `addr_r`/`data_r` change only in LOAD, so they are stable for the whole cycle.
- `busy` = state ∉ {IDLE, DONE, ERROR}.

## Timing
- Reset values: state IDLE, `ciclo`=0, `bus_out`=0x00, `bus_oe`=0, `busy`=0, `done`=0, `err`=0, `idx`=0, `addr_r`=`data_r`=0x00.
- `start` at edge N → LOAD at N+1, `ciclo` high in cycle N+2.
- `Fin` sampled high at edge M in WAIT → GAP at M+1, LOAD at M+2, next `ciclo` at M+3.
- On the last entry, `done` and `busy`=0 are visible the cycle after `Fin`.
- `bus_out`/`bus_oe` have zero latency from `Sent_A`/`Sent_D`.
- Reset mid-operation returns the block to IDLE on the next edge, with outputs as listed above. The write controller shares `Reset`, so both restart together.

## Configuration
- `RTC_INIT_COMMIT_EN` defined: table gains entry 4 = (0xF0, 0xF0), the transfer/commit command, and LAST = 4.
- Undefined: table ends at entry 3 and LAST = 3.
- In both cases `idx` stays 3 bits wide.

## Test plan
- Reset, then `start`, with a controller model returning `Fin` 130 cycles after each `ciclo` → exactly 4 `ciclo` pulses (5 with macro), each 133 cycles apart; `done`=1 and `idx`=3 (4) at end.
- During each entry, `Sent_A` pulse → `bus_out`=table addr and `bus_oe`=1; `Sent_D` pulse → table data; both low → `bus_out`=0x00, `bus_oe`=0.
- `Sent_A` and `Sent_D` high together on entry 0 → `bus_out`=0x02.
- No `Fin` after second `ciclo` → ERROR after 16384 cycles, `err`=1, `idx`=1, `busy`=0; a new `start` then reruns from `idx`=0 with `err` cleared.
- `start` re-pulsed while in WAIT, and spurious `Fin` in IDLE → no extra `ciclo`, no state change.
- `Reset` asserted in WAIT of entry 2 → next cycle IDLE, `idx`=0, `ciclo`=0, `busy`=0, `bus_oe` follows the strobes only.
